// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write-port arbiter: round-robin on conflict,
// registered write outputs with x0 suppression and a saturating conflict counter.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arb_enable,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              r_prio;
  logic [ADDR_W-1:0] r_a3;
  logic [DATA_W-1:0] r_write_data;
  logic              r_write_enable;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic w_both;
  logic w_grant0;
  logic w_grant1;

  // Grants are combinational; r_prio breaks ties and reset forces both low.
  assign w_both   = req0_valid & req1_valid;
  assign w_grant0 = reset & arb_enable & req0_valid & (~req1_valid | ~r_prio);
  assign w_grant1 = reset & arb_enable & req1_valid & (~req0_valid |  r_prio);

  assign req0_ready   = w_grant0;
  assign req1_ready   = w_grant1;
  assign a3           = r_a3;
  assign write_data   = r_write_data;
  assign write_enable = r_write_enable;
  assign conflict_cnt = r_conflict_cnt;

  // Write port capture; address 0 is accepted but never strobed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a3           <= '0;
      r_write_data   <= '0;
      r_write_enable <= 1'b0;
    end else if (w_grant0) begin
      r_a3           <= req0_addr;
      r_write_data   <= req0_data;
      r_write_enable <= |req0_addr;
    end else if (w_grant1) begin
      r_a3           <= req1_addr;
      r_write_data   <= req1_data;
      r_write_enable <= |req1_addr;
    end else begin
      r_write_enable <= 1'b0;
    end
  end

  // Priority passes to the loser of a granted conflict; counter saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio         <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_both && (w_grant0 || w_grant1)) begin
        r_prio <= w_grant0;
      end
      if (w_both && (r_conflict_cnt != CNT_MAX)) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a random
// handshake run against a behavioural model of the write port.
module tb_rf_write_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          arb_enable = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  logic          r0, r1, we;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd;
  logic [15:0]   cnt;
  logic          r0b, r1b, web;
  logic [AW-1:0] a3b;
  logic [DW-1:0] wdb;
  logic [1:0]    cntb;

  int total = 0;
  int bad = 0;

  // Model state: last write, conflict count (unbounded), favoured requester.
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd;
  logic          m_we;
  int            m_cnt;
  int            m_fav;
  logic          lg0, lg1;

  rf_write_arbiter u_dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1),
    .req0_ready(r0), .req1_ready(r1),
    .a3(a3), .write_data(wd), .write_enable(we), .conflict_cnt(cnt)
  );

  rf_write_arbiter #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .arb_enable(arb_enable),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1),
    .req0_ready(r0b), .req1_ready(r1b),
    .a3(a3b), .write_data(wdb), .write_enable(web), .conflict_cnt(cntb)
  );

  always #5 clk = ~clk;

  function automatic logic exp_r0();
    return reset && arb_enable && v0 && (!v1 || m_fav == 0);
  endfunction

  function automatic logic exp_r1();
    return reset && arb_enable && v1 && (!v0 || m_fav == 1);
  endfunction

  function automatic int exp_cnt(input int max);
    return (m_cnt > max) ? max : m_cnt;
  endfunction

  task automatic model_clear();
    m_a3 = '0; m_wd = '0; m_we = 1'b0; m_cnt = 0; m_fav = 0;
  endtask

  // Advance one clock and apply the write-port rules to the model.
  task automatic tick();
    lg0 = exp_r0();
    lg1 = exp_r1();
    @(posedge clk);
    if (reset) begin
      if (lg0) begin
        m_a3 = a0; m_wd = d0; m_we = (a0 != 0);
      end else if (lg1) begin
        m_a3 = a1; m_wd = d1; m_we = (a1 != 0);
      end else begin
        m_we = 1'b0;
      end
      if (v0 && v1) begin
        m_cnt++;
        if (lg0) m_fav = 1;
        else if (lg1) m_fav = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; v0 = 1'b0; v1 = 1'b0; arb_enable = 1'b1;
    model_clear();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    v0 = 1'b1; v1 = 1'b1; arb_enable = 1'b1; model_clear();
    #2;
    total++;
    if (r0 !== 1'b0 || r1 !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b%b want=00", r0, r1);
    end
    total++;
    if (a3 !== '0 || wd !== '0 || we !== 1'b0 || cnt !== '0) begin
      bad++; $display("FAIL reset_out got a3=%0d wd=%h we=%b cnt=%0d want all 0", a3, wd, we, cnt);
    end
    tick();
    total++;
    if (cnt !== '0 || we !== 1'b0) begin
      bad++; $display("FAIL reset_hold got cnt=%0d we=%b want 0 0", cnt, we);
    end
    v0 = 1'b0; v1 = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    v0 = 1'b1; a0 = AW'(5); d0 = 32'hDEADBEEF; #1;
    total++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      bad++; $display("FAIL single_ready got=%b%b want=10", r0, r1);
    end
    tick(); v0 = 1'b0; #1;
    total++;
    if (a3 !== AW'(5) || wd !== 32'hDEADBEEF || we !== 1'b1) begin
      bad++; $display("FAIL single_out got a3=%0d wd=%h we=%b want 5 deadbeef 1", a3, wd, we);
    end
    tick();
    total++;
    if (we !== 1'b0 || a3 !== AW'(5)) begin
      bad++; $display("FAIL single_idle got we=%b a3=%0d want 0 5", we, a3);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    v0 = 1'b1; a0 = AW'(1); d0 = 32'h11;
    v1 = 1'b1; a1 = AW'(2); d1 = 32'h22; #1;
    total++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      bad++; $display("FAIL conflict_c0 got=%b%b want=10", r0, r1);
    end
    tick(); v0 = 1'b0; #1;
    total++;
    if (a3 !== AW'(1) || wd !== 32'h11 || we !== 1'b1 || r1 !== 1'b1) begin
      bad++; $display("FAIL conflict_c1 got a3=%0d wd=%h we=%b r1=%b want 1 11 1 1", a3, wd, we, r1);
    end
    tick(); v1 = 1'b0; #1;
    total++;
    if (a3 !== AW'(2) || wd !== 32'h22 || we !== 1'b1 || cnt !== 16'd1) begin
      bad++; $display("FAIL conflict_c2 got a3=%0d wd=%h we=%b cnt=%0d want 2 22 1 1", a3, wd, we, cnt);
    end
  endtask

  task automatic test_sustained();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v0 = 1'b1; a0 = AW'($urandom_range(1, 31)); d0 = $urandom;
      v1 = 1'b1; a1 = AW'($urandom_range(1, 31)); d1 = $urandom; #1;
      total++;
      if (r0 !== ((i % 2) == 0) || r1 !== ((i % 2) == 1)) begin
        bad++; $display("FAIL sustained_grant%0d got=%b%b want req%0d", i, r0, r1, i % 2);
      end
      tick();
      total++;
      if (wd !== (((i % 2) == 0) ? d0 : d1) || we !== 1'b1) begin
        bad++; $display("FAIL sustained_data%0d got wd=%h we=%b want %h 1", i, wd, we, ((i % 2) == 0) ? d0 : d1);
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    total++;
    if (cnt !== 16'd6) begin
      bad++; $display("FAIL sustained_cnt got=%0d want=6", cnt);
    end
  endtask

  task automatic test_x0();
    do_reset();
    v1 = 1'b1; a1 = '0; d1 = 32'hFFFFFFFF; #1;
    total++;
    if (r1 !== 1'b1 || r0 !== 1'b0) begin
      bad++; $display("FAIL x0_ready got=%b%b want=01", r0, r1);
    end
    tick(); v1 = 1'b0;
    total++;
    if (a3 !== '0 || wd !== 32'hFFFFFFFF || we !== 1'b0) begin
      bad++; $display("FAIL x0_out got a3=%0d wd=%h we=%b want 0 ffffffff 0", a3, wd, we);
    end
  endtask

  task automatic test_gating();
    do_reset();
    arb_enable = 1'b0;
    v0 = 1'b1; a0 = AW'(3); d0 = 32'h33;
    v1 = 1'b1; a1 = AW'(4); d1 = 32'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (r0 !== 1'b0 || r1 !== 1'b0) begin
        bad++; $display("FAIL gate_ready%0d got=%b%b want=00", i, r0, r1);
      end
      tick();
      total++;
      if (we !== 1'b0) begin
        bad++; $display("FAIL gate_we%0d got=%b want=0", i, we);
      end
    end
    total++;
    if (cnt !== 16'd3) begin
      bad++; $display("FAIL gate_cnt got=%0d want=3", cnt);
    end
    arb_enable = 1'b1; #1;
    total++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      bad++; $display("FAIL gate_release got=%b%b want=10", r0, r1);
    end
    tick(); v0 = 1'b0; tick(); v1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    v0 = 1'b1; a0 = AW'(9); d0 = 32'hAAAA0000;
    v1 = 1'b1; a1 = AW'(9); d1 = 32'hBBBB0000; #1;
    tick(); if (lg0) v0 = 1'b0; if (lg1) v1 = 1'b0; #1;
    tick(); if (lg0) v0 = 1'b0; if (lg1) v1 = 1'b0;
    total++;
    if (a3 !== AW'(9) || wd !== 32'hBBBB0000 || we !== 1'b1 || v0 !== 1'b0 || v1 !== 1'b0) begin
      bad++; $display("FAIL b2b_same_addr got a3=%0d wd=%h we=%b want 9 bbbb0000 1", a3, wd, we);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    v0 = 1'b1; a0 = AW'(7); d0 = $urandom; #1;
    tick(); v0 = 1'b0;
    total++;
    if (we !== 1'b1 || a3 !== AW'(7)) begin
      bad++; $display("FAIL midrst_pre got we=%b a3=%0d want 1 7", we, a3);
    end
    #2; reset = 1'b0; v0 = 1'b1; v1 = 1'b1; model_clear(); #1;
    total++;
    if (a3 !== '0 || wd !== '0 || we !== 1'b0 || r0 !== 1'b0 || r1 !== 1'b0) begin
      bad++; $display("FAIL midrst_async got a3=%0d wd=%h we=%b rdy=%b%b want all 0", a3, wd, we, r0, r1);
    end
    tick(); reset = 1'b1; v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (we !== 1'b0) begin
        bad++; $display("FAIL midrst_we%0d got=%b want=0", i, we);
      end
    end
    arb_enable = 1'b0; v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (cntb !== 2'd3 || cnt !== 16'd5) begin
      bad++; $display("FAIL midrst_sat got cnt2=%0d cnt=%0d want 3 5", cntb, cnt);
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      arb_enable = ($urandom_range(0, 9) != 0);
      if (!v0 && $urandom_range(0, 2) != 0) begin
        v0 = 1'b1; a0 = AW'($urandom); d0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        v1 = 1'b1; a1 = AW'($urandom); d1 = $urandom;
      end
      #1;
      total++;
      if (r0 !== exp_r0() || r1 !== exp_r1()) begin
        bad++; $display("FAIL rand_ready%0d got=%b%b want=%b%b", i, r0, r1, exp_r0(), exp_r1());
      end
      tick();
      if (lg0) v0 = 1'b0;
      if (lg1) v1 = 1'b0;
      total++;
      if (a3 !== m_a3 || wd !== m_wd || we !== m_we || int'(cnt) != exp_cnt(65535) ||
          int'(cntb) != exp_cnt(3)) begin
        bad++; $display("FAIL rand_out%0d got a3=%0d wd=%h we=%b cnt=%0d/%0d want %0d %h %b %0d/%0d",
                        i, a3, wd, we, cnt, cntb, m_a3, m_wd, m_we, exp_cnt(65535), exp_cnt(3));
      end
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_sustained();
    test_x0();
    test_gating();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
